systolic_matmul_tile_engine: RTL

- Parametrised successor to the fixed-size buffered systolic array.
- Computes C[N×N] (+)= A[N×K] · B[K×N] on an N×N output-stationary MAC grid, with a runtime K (1..K_MAX), signed or unsigned INT operands and optional accumulation across tiles.
- Operands are streamed one K-beat per handshake and skewed internally; results drain row by row over a ready/valid stream.
- Sits between the DMA operand buffers and the result writeback path.

---
 rtl/systolic_matmul_tile_engine.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_tile_engine.sv
// Output-stationary N x N INT MAC tile: C (+)= A*B with runtime K, skewed operand streaming, row-wise drain.
// Optional macro ACC_SATURATE_EN: clamp accumulators to the signed/unsigned range and expose a sticky sat_flag.
module systolic_matmul_tile_engine #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int K_MAX      = 64,
    localparam int KW        = $clog2(K_MAX + 1),
    localparam int RW        = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    signed_mode,
    input  logic                    accumulate,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] a_col,
    input  logic [N*DATA_WIDTH-1:0] b_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*ACC_WIDTH-1:0]  out_data,
    output logic [RW-1:0]           out_row,
    output logic                    out_last,
    output logic                    busy,
`ifdef ACC_SATURATE_EN
    output logic                    sat_flag,
`endif
    output logic                    done
);

    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;
    localparam int PW  = 2 * DATA_WIDTH + 2;
    localparam int DCW = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_len_q, k_len_d;
    logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic            signed_q, signed_d;
    logic            done_q, done_d;
    logic            beat, acc_clr, acc_run;

    logic [DW-1:0]   inj_a [N];
    logic [DW-1:0]   inj_b [N];
    logic [DW-1:0]   a_in  [N][N];
    logic [DW-1:0]   b_in  [N][N];
    logic [AW-1:0]   acc   [N][N];

`ifdef ACC_SATURATE_EN
    logic            sat_hit [N][N];
    logic            sat_any;
    logic            sat_flag_q, sat_flag_d;
`endif

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        row_d       = row_q;
        signed_d    = signed_q;
        done_d      = 1'b0;
        beat        = 1'b0;
        acc_clr     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
`ifdef ACC_SATURATE_EN
        sat_flag_d  = sat_flag_q | sat_any;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_len_d    = k_len;
                    signed_d   = signed_mode;
                    beat_cnt_d = '0;
                    row_d      = '0;
                    acc_clr    = !accumulate;
`ifdef ACC_SATURATE_EN
                    sat_flag_d = 1'b0;
`endif
                    state_d    = (k_len == '0) ? S_OUTPUT : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                beat     = in_valid;
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == k_len_q - 1'b1) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DCW'(2 * N - 2)) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign acc_run = (state_q == S_LOAD) || (state_q == S_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            row_q       <= '0;
            signed_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            row_q       <= row_d;
            signed_q    <= signed_d;
            done_q      <= done_d;
        end
    end

    // Bubble cycles inject zeros on both edges so A/B alignment survives stalls.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            inj_a[i] = beat ? a_col[i*DW +: DW] : '0;
            inj_b[i] = beat ? b_row[i*DW +: DW] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_in[0][0] = inj_a[0];
            assign b_in[0][0] = inj_b[0];
        end else begin : g_delay
            logic [i*DW-1:0] ska_q, ska_d, skb_q, skb_d;
            if (i == 1) begin : g_one
                always_comb begin
                    ska_d = inj_a[i];
                    skb_d = inj_b[i];
                end
            end else begin : g_many
                always_comb begin
                    ska_d = {ska_q[(i-1)*DW-1:0], inj_a[i]};
                    skb_d = {skb_q[(i-1)*DW-1:0], inj_b[i]};
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ska_q <= '0;
                    skb_q <= '0;
                end else begin
                    ska_q <= ska_d;
                    skb_q <= skb_d;
                end
            end
            assign a_in[i][0] = ska_q[i*DW-1 -: DW];
            assign b_in[0][i] = skb_q[i*DW-1 -: DW];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic signed [DW:0]   a_x, b_x;
            logic signed [PW-1:0] prod_full;
            logic [AW-1:0]        prod_ext, sum, acc_q, acc_d;

            if (j < N - 1) begin : g_pass_a
                logic [DW-1:0] a_q, a_d;
                always_comb a_d = a_in[i][j];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) a_q <= '0;
                    else     a_q <= a_d;
                end
                assign a_in[i][j+1] = a_q;
            end
            if (i < N - 1) begin : g_pass_b
                logic [DW-1:0] b_q, b_d;
                always_comb b_d = b_in[i][j];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) b_q <= '0;
                    else     b_q <= b_d;
                end
                assign b_in[i+1][j] = b_q;
            end

            // One extra operand bit makes a single signed multiply serve both modes.
            always_comb begin
                a_x       = {signed_q & a_in[i][j][DW-1], a_in[i][j]};
                b_x       = {signed_q & b_in[i][j][DW-1], b_in[i][j]};
                prod_full = PW'(a_x) * PW'(b_x);
                prod_ext  = AW'(prod_full);
            end

`ifdef ACC_SATURATE_EN
            logic [AW:0] sum_x;
            logic        ovf;
            always_comb begin
                if (signed_q) begin
                    sum_x = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
                    ovf   = sum_x[AW] ^ sum_x[AW-1];
                    if (ovf) sum = sum_x[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                    else     sum = sum_x[AW-1:0];
                end else begin
                    sum_x = {1'b0, acc_q} + {1'b0, prod_ext};
                    ovf   = sum_x[AW];
                    sum   = ovf ? '1 : sum_x[AW-1:0];
                end
            end
            assign sat_hit[i][j] = acc_run && ovf;
`else
            always_comb sum = acc_q + prod_ext;
`endif

            always_comb begin
                acc_d = acc_q;
                if (acc_clr)      acc_d = '0;
                else if (acc_run) acc_d = sum;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) acc_q <= '0;
                else     acc_q <= acc_d;
            end
            assign acc[i][j] = acc_q;
        end
    end

`ifdef ACC_SATURATE_EN
    always_comb begin
        sat_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                sat_any = sat_any | sat_hit[i][j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_flag_q <= 1'b0;
        else     sat_flag_q <= sat_flag_d;
    end
    assign sat_flag = sat_flag_q;
`endif

    always_comb begin
        out_data = '0;
        out_row  = '0;
        out_last = 1'b0;
        if (state_q == S_OUTPUT) begin
            for (int unsigned j = 0; j < N; j++) begin
                out_data[j*AW +: AW] = acc[row_q][j];
            end
            out_row  = row_q;
            out_last = (row_q == RW'(N - 1));
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule
